// File: rtl/mc_control.sv
// mc_control: multicycle main control FSM (Moore) for a MIPS-style datapath.
// Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq, j, ori.
// Optional feature macro: ILLEGAL_OP_TRAP_EN
//   defined   -> an illegal opcode in DECODE parks the FSM in TRAP with illegal_op = 1
//   undefined -> an illegal opcode returns to FETCH (no-op) and illegal_op stays 0
module mc_control #(
   parameter int OPW = 6
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [OPW-1:0] opcode,
   output logic           pcwrite,
   output logic           pcwritecond,
   output logic           iord,
   output logic           memread,
   output logic           memwrite,
   output logic           irwrite,
   output logic           memtoreg,
   output logic           regdst,
   output logic           regwrite,
   output logic           alusrca,
   output logic [1:0]     alusrcb,
   output logic           zeroext,
   output logic           aluop1,
   output logic           aluop0,
   output logic [1:0]     pcsource,
   output logic           illegal_op,
   output logic [3:0]     state
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_ORIEX  = 4'd11,
      S_ORIWB  = 4'd12,
      S_TRAP   = 4'd13
   } state_t;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       zeroext;
      logic [1:0] aluop;
      logic [1:0] pcsource;
      logic       illegal;
   } ctrl_t;

   localparam logic [OPW-1:0] OP_R   = 6'b000000;
   localparam logic [OPW-1:0] OP_LW  = 6'b100011;
   localparam logic [OPW-1:0] OP_SW  = 6'b101011;
   localparam logic [OPW-1:0] OP_BEQ = 6'b000100;
   localparam logic [OPW-1:0] OP_J   = 6'b000010;
   localparam logic [OPW-1:0] OP_ORI = 6'b001101;

   state_t cur;
   state_t nxt;
   ctrl_t  ctrl_q;

   // Per-state control word; anything not set stays 0 so each state only names its active strobes.
   function automatic ctrl_t decode(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.memread = 1'b1;
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.alusrcb = 2'b01;
         end
         S_DECODE: c.alusrcb = 2'b11;
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         S_MEMRD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         S_MEMWR: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         S_EXEC: begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b10;
         end
         S_RWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca     = 1'b1;
            c.aluop       = 2'b01;
            c.pcwritecond = 1'b1;
            c.pcsource    = 2'b01;
         end
         S_JUMP: begin
            c.pcwrite  = 1'b1;
            c.pcsource = 2'b10;
         end
         S_ORIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.zeroext = 1'b1;
            c.aluop   = 2'b11;
         end
         S_ORIWB: c.regwrite = 1'b1;
         S_TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
            c.illegal = 1'b1;
`endif
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Next-state selection; opcode only matters in DECODE and MEMADR.
   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_RST:    nxt = S_FETCH;
         S_FETCH:  nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:         nxt = S_EXEC;
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_BEQ:       nxt = S_BRANCH;
               OP_J:         nxt = S_JUMP;
               OP_ORI:       nxt = S_ORIEX;
`ifdef ILLEGAL_OP_TRAP_EN
               default:      nxt = S_TRAP;
`else
               default:      nxt = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  nxt = S_MEMWB;
         S_EXEC:   nxt = S_RWB;
         S_ORIEX:  nxt = S_ORIWB;
`ifdef ILLEGAL_OP_TRAP_EN
         S_TRAP:   nxt = S_TRAP;
`else
         S_TRAP:   nxt = S_FETCH;
`endif
         default:  nxt = S_FETCH;
      endcase
   end

   // State and control word register together, so outputs are glitch-free and drop at once on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur    <= S_RST;
         ctrl_q <= '0;
      end else begin
         cur    <= nxt;
         ctrl_q <= decode(nxt);
      end
   end

   assign pcwrite     = ctrl_q.pcwrite;
   assign pcwritecond = ctrl_q.pcwritecond;
   assign iord        = ctrl_q.iord;
   assign memread     = ctrl_q.memread;
   assign memwrite    = ctrl_q.memwrite;
   assign irwrite     = ctrl_q.irwrite;
   assign memtoreg    = ctrl_q.memtoreg;
   assign regdst      = ctrl_q.regdst;
   assign regwrite    = ctrl_q.regwrite;
   assign alusrca     = ctrl_q.alusrca;
   assign alusrcb     = ctrl_q.alusrcb;
   assign zeroext     = ctrl_q.zeroext;
   assign aluop1      = ctrl_q.aluop[1];
   assign aluop0      = ctrl_q.aluop[0];
   assign pcsource    = ctrl_q.pcsource;
   assign illegal_op  = ctrl_q.illegal;
   assign state       = cur;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: self-checking bench for mc_control using random instruction streams
// against a table-driven reference of instruction state paths and per-state strobes.
module tb_mc_control;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
   logic       memtoreg, regdst, regwrite, alusrca, zeroext, aluop1, aluop0, illegal_op;
   logic [1:0] alusrcb, pcsource;
   logic [3:0] state;

   int checks   = 0;
   int failures = 0;

   mc_control #(.OPW(6)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
      .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
      .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext),
      .aluop1(aluop1), .aluop0(aluop0), .pcsource(pcsource),
      .illegal_op(illegal_op), .state(state)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   logic [17:0] obs;
   assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
                 regwrite, alusrca, alusrcb, zeroext, aluop1, aluop0, pcsource, illegal_op};

   // Reference control word for a state code, straight from the per-state output table.
   function automatic logic [17:0] expCtrl(input int s);
      logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, ir = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
      logic zx = 0, il = 0;
      logic [1:0] sb = 0, op = 0, ps = 0;
      case (s)
         1:  begin mr = 1; ir = 1; pw = 1; sb = 2'b01; end
         2:  sb = 2'b11;
         3:  begin sa = 1; sb = 2'b10; end
         4:  begin mr = 1; io = 1; end
         5:  begin rw = 1; m2r = 1; end
         6:  begin mw = 1; io = 1; end
         7:  begin sa = 1; op = 2'b10; end
         8:  begin rw = 1; rd = 1; end
         9:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
         10: begin pw = 1; ps = 2'b10; end
         11: begin sa = 1; sb = 2'b10; zx = 1; op = 2'b11; end
         12: rw = 1;
         13: il = 1;
         default: ;
      endcase
      return {pw, pwc, io, mr, mw, ir, m2r, rd, rw, sa, sb, zx, op[1], op[0], ps, il};
   endfunction

   function automatic bit isLegal(input logic [5:0] op);
      return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
             op == 6'b000100 || op == 6'b000010 || op == 6'b001101;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
      end
   endtask

   // Runs one instruction starting in FETCH, checking state, strobes and exclusivity every cycle.
   task automatic applyStimulus(input logic [5:0] op);
      int seq[$];
      seq = {1, 2};
      case (op)
         6'b000000: seq = {seq, 7, 8};
         6'b100011: seq = {seq, 3, 4, 5};
         6'b101011: seq = {seq, 3, 6};
         6'b000100: seq = {seq, 9};
         6'b000010: seq = {seq, 10};
         6'b001101: seq = {seq, 11, 12};
         default: ;
      endcase
      for (int i = 0; i < seq.size(); i++) begin
         checkOutput($sformatf("state op=%b step=%0d", op, i), 32'(state), 32'(seq[i]));
         checkOutput($sformatf("ctrl st=%0d", seq[i]), 32'(obs), 32'(expCtrl(seq[i])));
         checkOutput("mem_excl", 32'(memread & memwrite), 32'd0);
         checkOutput("pc_excl", 32'(pcwrite & pcwritecond), 32'd0);
         if (seq[i] == 2 || seq[i] == 3) opcode = op;
         else opcode = 6'($urandom);
         @(negedge clk);
      end
   endtask

   logic [5:0] rop;

   initial begin
      reset_n = 1'b0;
      opcode  = 6'b100011;
      #3;
      checkOutput("reset_state", 32'(state), 32'd0);
      checkOutput("reset_ctrl", 32'(obs), 32'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_hold_state", 32'(state), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed lw, R-type, ori, beq, j");
      applyStimulus(6'b100011);
      applyStimulus(6'b000000);
      applyStimulus(6'b001101);
      applyStimulus(6'b000100);
      applyStimulus(6'b000010);
`ifndef ILLEGAL_OP_TRAP_EN
      applyStimulus(6'b111111);
      checkOutput("illegal_noop_back_to_fetch", 32'(state), 32'd1);
      checkOutput("illegal_op_low", 32'(illegal_op), 32'd0);
`endif

      $display("[TB] random instruction stream");
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 6))
            0: rop = 6'b000000;
            1: rop = 6'b100011;
            2: rop = 6'b101011;
            3: rop = 6'b000100;
            4: rop = 6'b000010;
            5: rop = 6'b001101;
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
               rop = 6'b000000;
`else
               rop = 6'($urandom);
               while (isLegal(rop)) rop = 6'($urandom);
`endif
            end
         endcase
         applyStimulus(rop);
      end

      $display("[TB] reset asserted during MEMWR");
      checkOutput("sw_fetch", 32'(state), 32'd1);
      opcode = 6'b101011;
      @(negedge clk);
      checkOutput("sw_decode", 32'(state), 32'd2);
      @(negedge clk);
      checkOutput("sw_memadr", 32'(state), 32'd3);
      @(negedge clk);
      checkOutput("sw_memwr", 32'(state), 32'd6);
      checkOutput("sw_memwrite", 32'(memwrite), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midreset_state", 32'(state), 32'd0);
      checkOutput("midreset_ctrl", 32'(obs), 32'd0);
      @(negedge clk);
      checkOutput("midreset_hold", 32'(state), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_fetch", 32'(state), 32'd1);
      checkOutput("post_reset_ctrl", 32'(obs), 32'(expCtrl(1)));

`ifdef ILLEGAL_OP_TRAP_EN
      $display("[TB] illegal opcode trap");
      opcode = 6'b111111;
      @(negedge clk);
      checkOutput("trap_decode", 32'(state), 32'd2);
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         opcode = 6'($urandom);
         checkOutput("trap_state", 32'(state), 32'd13);
         checkOutput("trap_ctrl", 32'(obs), 32'(expCtrl(13)));
         @(negedge clk);
      end
      reset_n = 1'b0;
      #1;
      checkOutput("trap_reset_ctrl", 32'(obs), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("trap_release_fetch", 32'(state), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
